// File: rtl/tpu_bridge_pkg.sv
// Shared types for the UART-to-MLP bridge: config byte map, identity defaults, activation config struct.
// Latency: n/a (declarations only). Backpressure: n/a.
package tpu_bridge_pkg;

    localparam logic [3:0] CFG_GAIN_B0  = 4'd0;
    localparam logic [3:0] CFG_GAIN_B1  = 4'd1;
    localparam logic [3:0] CFG_BIAS_B0  = 4'd2;
    localparam logic [3:0] CFG_BIAS_B1  = 4'd3;
    localparam logic [3:0] CFG_BIAS_B2  = 4'd4;
    localparam logic [3:0] CFG_BIAS_B3  = 4'd5;
    localparam logic [3:0] CFG_SHIFT    = 4'd6;
    localparam logic [3:0] CFG_INV_B0   = 4'd7;
    localparam logic [3:0] CFG_INV_B1   = 4'd8;
    localparam logic [3:0] CFG_ZP       = 4'd9;

    localparam logic signed [15:0] DEF_GAIN      = 16'sd256;
    localparam logic signed [31:0] DEF_BIAS      = 32'sd0;
    localparam logic [4:0]         DEF_SHIFT     = 5'd8;
    localparam logic signed [15:0] DEF_INV_SCALE = 16'sd256;
    localparam logic signed [7:0]  DEF_ZP        = 8'sd0;

    typedef struct packed {
        logic signed [15:0] gain;
        logic signed [31:0] bias;
        logic [4:0]         shift;
        logic signed [15:0] inv_scale;
        logic signed [7:0]  zp;
    } act_cfg_t;

    localparam act_cfg_t ACT_CFG_IDENTITY = '{
        gain:      DEF_GAIN,
        bias:      DEF_BIAS,
        shift:     DEF_SHIFT,
        inv_scale: DEF_INV_SCALE,
        zp:        DEF_ZP
    };

endpackage

// File: rtl/tpu_act_cfg_regs.sv
// Activation config shadow/active registers with idle-gated commit and start deferral.
// Latency: active updates 1 edge after an idle commit; deferred start re-issued 1 cycle after apply. Backpressure: none (cfg_busy is status only).
module tpu_act_cfg_regs
    import tpu_bridge_pkg::*;
#(
    parameter logic [3:0] IDLE_STATE = 4'd0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_wr_en,
    input  logic [3:0] i_addr,
    input  logic [7:0] i_wr_data,
    input  logic       i_commit,
    input  logic [3:0] i_state,
    input  logic       i_start,
    output logic       o_start_req,
    output act_cfg_t   o_active,
    output logic       o_busy,
    output logic       o_addr_err
);

    act_cfg_t r_shadow;
    act_cfg_t r_active;
    act_cfg_t w_shadow_nxt;
    logic     r_pending;
    logic     r_start_held;
    logic     r_start_go;
    logic     w_idle;
    logic     w_apply;
    logic     w_pending_apply;
    logic     w_defer_start;
    logic     w_start_held;

    always_comb begin
        w_shadow_nxt = r_shadow;
        case (i_addr)
            CFG_GAIN_B0: w_shadow_nxt.gain[7:0]       = i_wr_data;
            CFG_GAIN_B1: w_shadow_nxt.gain[15:8]      = i_wr_data;
            CFG_BIAS_B0: w_shadow_nxt.bias[7:0]       = i_wr_data;
            CFG_BIAS_B1: w_shadow_nxt.bias[15:8]      = i_wr_data;
            CFG_BIAS_B2: w_shadow_nxt.bias[23:16]     = i_wr_data;
            CFG_BIAS_B3: w_shadow_nxt.bias[31:24]     = i_wr_data;
            CFG_SHIFT:   w_shadow_nxt.shift           = i_wr_data[4:0];
            CFG_INV_B0:  w_shadow_nxt.inv_scale[7:0]  = i_wr_data;
            CFG_INV_B1:  w_shadow_nxt.inv_scale[15:8] = i_wr_data;
            CFG_ZP:      w_shadow_nxt.zp              = i_wr_data;
            default:     w_shadow_nxt = r_shadow;
        endcase
    end

    assign o_addr_err      = i_wr_en && (i_addr > CFG_ZP);
    assign w_idle          = (i_state == IDLE_STATE);
    assign w_apply         = w_idle && (i_commit || r_pending);
    assign w_pending_apply = w_idle && r_pending;
    // A start that would race a not-yet-applied config is held until the config lands.
    assign w_defer_start   = i_start && (r_pending || (i_commit && !w_idle));
    assign w_start_held    = r_start_held || w_defer_start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow     <= ACT_CFG_IDENTITY;
            r_active     <= ACT_CFG_IDENTITY;
            r_pending    <= 1'b0;
            r_start_held <= 1'b0;
            r_start_go   <= 1'b0;
        end else begin
            if (i_wr_en && !o_addr_err) begin
                r_shadow <= w_shadow_nxt;
            end
            if (w_apply) begin
                r_active <= r_shadow;
            end
            r_pending    <= r_pending ? !w_idle : (i_commit && !w_idle);
            r_start_held <= w_start_held && !w_pending_apply;
            r_start_go   <= w_start_held && w_pending_apply;
        end
    end

    assign o_start_req = (i_start && !w_defer_start) || r_start_go;
    assign o_active    = r_active;
    assign o_busy      = r_pending;

endmodule

// File: rtl/tpu_bridge_cfg.sv
// UART-controller to mlp_top bridge: registered control forwards, weight-push column demux, runtime activation config, DONE result capture.
// Latency: 1 cycle on every forward. Backpressure: none; results held until result_ack, overrun flagged sticky in result_ovf.
module tpu_bridge_cfg
    import tpu_bridge_pkg::*;
#(
    parameter int         NUM_COLS   = 2,
    parameter int         ACC_W      = 32,
    parameter logic [3:0] IDLE_STATE = 4'd0,
    parameter logic [3:0] DONE_STATE = 4'd9,
    localparam int        CW         = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ctrl_wf_push,
    input  logic [CW-1:0]             ctrl_wf_col_sel,
    input  logic [7:0]                ctrl_wf_data_in,
    input  logic                      ctrl_wf_reset,
    input  logic                      ctrl_init_act_valid,
    input  logic [15:0]               ctrl_init_act_data,
    input  logic                      ctrl_start_mlp,
    input  logic                      ctrl_weights_ready,
    input  logic                      cfg_wr_en,
    input  logic [3:0]                cfg_addr,
    input  logic [7:0]                cfg_wr_data,
    input  logic                      cfg_commit,
    output logic                      cfg_busy,
    output logic                      ctrl_err,
    output logic [NUM_COLS-1:0]       mlp_wf_push,
    output logic [7:0]                mlp_wf_data_in,
    output logic                      mlp_wf_reset,
    output logic                      mlp_init_act_valid,
    output logic [15:0]               mlp_init_act_data,
    output logic                      mlp_start_mlp,
    output logic                      mlp_weights_ready,
    output logic signed [15:0]        mlp_norm_gain,
    output logic signed [31:0]        mlp_norm_bias,
    output logic [4:0]                mlp_norm_shift,
    output logic signed [15:0]        mlp_q_inv_scale,
    output logic signed [7:0]         mlp_q_zero_point,
    input  logic [3:0]                mlp_state_in,
    input  logic [4:0]                mlp_cycle_cnt_in,
    input  logic [NUM_COLS*ACC_W-1:0] mlp_acc_in,
    output logic [3:0]                mlp_state,
    output logic [4:0]                mlp_cycle_cnt,
    output logic [NUM_COLS*ACC_W-1:0] result_acc,
    output logic                      result_valid,
    input  logic                      result_ack,
    output logic                      result_ovf
);

    logic [NUM_COLS-1:0]       r_wf_push;
    logic [7:0]                r_wf_data;
    logic                      r_wf_reset;
    logic                      r_init_vld;
    logic [15:0]               r_init_dat;
    logic                      r_start;
    logic                      r_wts_rdy;
    logic [3:0]                r_state;
    logic [3:0]                r_state_d;
    logic [4:0]                r_cycle_cnt;
    logic                      r_err;
    logic [NUM_COLS*ACC_W-1:0] r_res_acc;
    logic                      r_res_vld;
    logic                      r_res_ovf;

    logic [NUM_COLS-1:0]       w_push;
    logic                      w_col_ok;
    logic                      w_col_err;
    logic                      w_addr_err;
    logic                      w_start_req;
    logic                      w_capture;
    act_cfg_t                  w_active;

    tpu_act_cfg_regs #(
        .IDLE_STATE (IDLE_STATE)
    ) u_cfg (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_wr_en     (cfg_wr_en),
        .i_addr      (cfg_addr),
        .i_wr_data   (cfg_wr_data),
        .i_commit    (cfg_commit),
        .i_state     (r_state),
        .i_start     (ctrl_start_mlp),
        .o_start_req (w_start_req),
        .o_active    (w_active),
        .o_busy      (cfg_busy),
        .o_addr_err  (w_addr_err)
    );

    assign w_col_ok  = (int'(ctrl_wf_col_sel) < NUM_COLS);
    assign w_col_err = ctrl_wf_push && !w_col_ok;

    always_comb begin
        w_push = '0;
        if (ctrl_wf_push && w_col_ok) begin
            w_push[ctrl_wf_col_sel] = 1'b1;
        end
    end

    // Capture on the registered state's entry into DONE, not while it dwells there.
    assign w_capture = (r_state == DONE_STATE) && (r_state_d != DONE_STATE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wf_push   <= '0;
            r_wf_data   <= '0;
            r_wf_reset  <= 1'b0;
            r_init_vld  <= 1'b0;
            r_init_dat  <= '0;
            r_start     <= 1'b0;
            r_wts_rdy   <= 1'b0;
            r_state     <= '0;
            r_state_d   <= '0;
            r_cycle_cnt <= '0;
            r_err       <= 1'b0;
        end else begin
            r_wf_push   <= w_push;
            r_wf_data   <= ctrl_wf_data_in;
            r_wf_reset  <= ctrl_wf_reset;
            r_init_vld  <= ctrl_init_act_valid;
            r_init_dat  <= ctrl_init_act_data;
            r_start     <= w_start_req;
            r_wts_rdy   <= ctrl_weights_ready;
            r_state     <= mlp_state_in;
            r_state_d   <= r_state;
            r_cycle_cnt <= mlp_cycle_cnt_in;
            r_err       <= w_col_err || w_addr_err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_acc <= '0;
            r_res_vld <= 1'b0;
            r_res_ovf <= 1'b0;
        end else if (w_capture) begin
            r_res_acc <= mlp_acc_in;
            r_res_vld <= 1'b1;
            r_res_ovf <= result_ack ? 1'b0 : (r_res_ovf || r_res_vld);
        end else if (result_ack) begin
            r_res_vld <= 1'b0;
            r_res_ovf <= 1'b0;
        end
    end

    assign mlp_wf_push        = r_wf_push;
    assign mlp_wf_data_in     = r_wf_data;
    assign mlp_wf_reset       = r_wf_reset;
    assign mlp_init_act_valid = r_init_vld;
    assign mlp_init_act_data  = r_init_dat;
    assign mlp_start_mlp      = r_start;
    assign mlp_weights_ready  = r_wts_rdy;
    assign mlp_state          = r_state;
    assign mlp_cycle_cnt      = r_cycle_cnt;
    assign ctrl_err           = r_err;
    assign mlp_norm_gain      = w_active.gain;
    assign mlp_norm_bias      = w_active.bias;
    assign mlp_norm_shift     = w_active.shift;
    assign mlp_q_inv_scale    = w_active.inv_scale;
    assign mlp_q_zero_point   = w_active.zp;
    assign result_acc         = r_res_acc;
    assign result_valid       = r_res_vld;
    assign result_ovf         = r_res_ovf;

endmodule

// File: tb/tb_tpu_bridge_cfg.sv
// Directed bench for tpu_bridge_cfg with three weight columns so an out-of-range col_sel is reachable.
// Latency/backpressure: inputs driven and outputs sampled 1 time unit after each rising edge.
module tb_tpu_bridge_cfg;

    localparam int NC = 3;
    localparam int AW = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             ctrl_wf_push;
    logic [1:0]       ctrl_wf_col_sel;
    logic [7:0]       ctrl_wf_data_in;
    logic             ctrl_wf_reset;
    logic             ctrl_init_act_valid;
    logic [15:0]      ctrl_init_act_data;
    logic             ctrl_start_mlp;
    logic             ctrl_weights_ready;
    logic             cfg_wr_en;
    logic [3:0]       cfg_addr;
    logic [7:0]       cfg_wr_data;
    logic             cfg_commit;
    logic             cfg_busy;
    logic             ctrl_err;
    logic [NC-1:0]    mlp_wf_push;
    logic [7:0]       mlp_wf_data_in;
    logic             mlp_wf_reset;
    logic             mlp_init_act_valid;
    logic [15:0]      mlp_init_act_data;
    logic             mlp_start_mlp;
    logic             mlp_weights_ready;
    logic signed [15:0] mlp_norm_gain;
    logic signed [31:0] mlp_norm_bias;
    logic [4:0]       mlp_norm_shift;
    logic signed [15:0] mlp_q_inv_scale;
    logic signed [7:0]  mlp_q_zero_point;
    logic [3:0]       mlp_state_in;
    logic [4:0]       mlp_cycle_cnt_in;
    logic [NC*AW-1:0] mlp_acc_in;
    logic [3:0]       mlp_state;
    logic [4:0]       mlp_cycle_cnt;
    logic [NC*AW-1:0] result_acc;
    logic             result_valid;
    logic             result_ack;
    logic             result_ovf;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    tpu_bridge_cfg #(
        .NUM_COLS   (NC),
        .ACC_W      (AW),
        .IDLE_STATE (4'd0),
        .DONE_STATE (4'd9)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .ctrl_wf_push        (ctrl_wf_push),
        .ctrl_wf_col_sel     (ctrl_wf_col_sel),
        .ctrl_wf_data_in     (ctrl_wf_data_in),
        .ctrl_wf_reset       (ctrl_wf_reset),
        .ctrl_init_act_valid (ctrl_init_act_valid),
        .ctrl_init_act_data  (ctrl_init_act_data),
        .ctrl_start_mlp      (ctrl_start_mlp),
        .ctrl_weights_ready  (ctrl_weights_ready),
        .cfg_wr_en           (cfg_wr_en),
        .cfg_addr            (cfg_addr),
        .cfg_wr_data         (cfg_wr_data),
        .cfg_commit          (cfg_commit),
        .cfg_busy            (cfg_busy),
        .ctrl_err            (ctrl_err),
        .mlp_wf_push         (mlp_wf_push),
        .mlp_wf_data_in      (mlp_wf_data_in),
        .mlp_wf_reset        (mlp_wf_reset),
        .mlp_init_act_valid  (mlp_init_act_valid),
        .mlp_init_act_data   (mlp_init_act_data),
        .mlp_start_mlp       (mlp_start_mlp),
        .mlp_weights_ready   (mlp_weights_ready),
        .mlp_norm_gain       (mlp_norm_gain),
        .mlp_norm_bias       (mlp_norm_bias),
        .mlp_norm_shift      (mlp_norm_shift),
        .mlp_q_inv_scale     (mlp_q_inv_scale),
        .mlp_q_zero_point    (mlp_q_zero_point),
        .mlp_state_in        (mlp_state_in),
        .mlp_cycle_cnt_in    (mlp_cycle_cnt_in),
        .mlp_acc_in          (mlp_acc_in),
        .mlp_state           (mlp_state),
        .mlp_cycle_cnt       (mlp_cycle_cnt),
        .result_acc          (result_acc),
        .result_valid        (result_valid),
        .result_ack          (result_ack),
        .result_ovf          (result_ovf)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_wr(input logic [3:0] a, input logic [7:0] d);
        cfg_wr_en   = 1'b1;
        cfg_addr    = a;
        cfg_wr_data = d;
        step();
        cfg_wr_en   = 1'b0;
    endtask

    task automatic commit();
        cfg_commit = 1'b1;
        step();
        cfg_commit = 1'b0;
    endtask

    task automatic chk_identity(input string tag);
        chk({tag, "_gain"},  $unsigned(mlp_norm_gain),    16'd256);
        chk({tag, "_bias"},  $unsigned(mlp_norm_bias),    32'd0);
        chk({tag, "_shift"}, mlp_norm_shift,              5'd8);
        chk({tag, "_inv"},   $unsigned(mlp_q_inv_scale),  16'd256);
        chk({tag, "_zp"},    $unsigned(mlp_q_zero_point), 8'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        ctrl_wf_push = 0; ctrl_wf_col_sel = '0; ctrl_wf_data_in = '0; ctrl_wf_reset = 0;
        ctrl_init_act_valid = 0; ctrl_init_act_data = '0; ctrl_start_mlp = 0; ctrl_weights_ready = 0;
        cfg_wr_en = 0; cfg_addr = '0; cfg_wr_data = '0; cfg_commit = 0;
        mlp_state_in = 4'd0; mlp_cycle_cnt_in = '0; mlp_acc_in = '0; result_ack = 0;
        #22;
        chk_identity("rst");
        chk("rst_push", mlp_wf_push, 3'b000);
        chk("rst_valid", result_valid, 1'b0);
        chk("rst_busy", cfg_busy, 1'b0);
        rst_n = 1'b1;
        step();

        // Push demux and forwards
        ctrl_wf_push = 1; ctrl_wf_col_sel = 2'd2; ctrl_wf_data_in = 8'h5A;
        ctrl_init_act_valid = 1; ctrl_init_act_data = 16'hBEEF; ctrl_weights_ready = 1; ctrl_wf_reset = 1;
        mlp_cycle_cnt_in = 5'd17;
        chk("pre_push", mlp_wf_push, 3'b000);
        step();
        chk("push_c2", mlp_wf_push, 3'b100);
        chk("push_dat", mlp_wf_data_in, 8'h5A);
        chk("fwd_init_vld", mlp_init_act_valid, 1'b1);
        chk("fwd_init_dat", mlp_init_act_data, 16'hBEEF);
        chk("fwd_wts_rdy", mlp_weights_ready, 1'b1);
        chk("fwd_wf_reset", mlp_wf_reset, 1'b1);
        chk("fwd_cycle", mlp_cycle_cnt, 5'd17);
        chk("push_noerr", ctrl_err, 1'b0);
        ctrl_wf_col_sel = 2'd3; ctrl_wf_data_in = 8'hC3;
        ctrl_init_act_valid = 0; ctrl_weights_ready = 0; ctrl_wf_reset = 0;
        step();
        chk("push_bad", mlp_wf_push, 3'b000);
        chk("push_bad_err", ctrl_err, 1'b1);
        chk("wfreset_cfg", $unsigned(mlp_norm_gain), 16'd256);
        ctrl_wf_col_sel = 2'd0;
        step();
        chk("push_c0", mlp_wf_push, 3'b001);
        chk("err_pulse", ctrl_err, 1'b0);
        ctrl_wf_push = 0;
        step();
        chk("push_idle", mlp_wf_push, 3'b000);

        // Idle commit of bias, plus other fields
        cfg_wr(4'd2, 8'h78); cfg_wr(4'd3, 8'h56); cfg_wr(4'd4, 8'h34); cfg_wr(4'd5, 8'h12);
        chk("bias_shadow_only", $unsigned(mlp_norm_bias), 32'd0);
        commit();
        chk("bias_commit", $unsigned(mlp_norm_bias), 32'h12345678);
        cfg_wr(4'd12, 8'hFF);
        chk("addr_err", ctrl_err, 1'b1);
        cfg_wr(4'd6, 8'hE7); cfg_wr(4'd7, 8'h34); cfg_wr(4'd8, 8'h12); cfg_wr(4'd9, 8'h80);
        commit();
        chk("gain_unchanged", $unsigned(mlp_norm_gain), 16'd256);
        chk("bias_keep", $unsigned(mlp_norm_bias), 32'h12345678);
        chk("shift_trunc", mlp_norm_shift, 5'd7);
        chk("inv_scale", $unsigned(mlp_q_inv_scale), 16'h1234);
        chk("zp_neg", $unsigned(mlp_q_zero_point), 8'h80);

        // Deferred commit and start while busy
        mlp_state_in = 4'd3;
        step();
        chk("state_fwd", mlp_state, 4'd3);
        cfg_wr(4'd0, 8'h00); cfg_wr(4'd1, 8'h02);
        cfg_commit = 1; ctrl_start_mlp = 1;
        step();
        cfg_commit = 0; ctrl_start_mlp = 0;
        chk("busy_set", cfg_busy, 1'b1);
        chk("busy_gain", $unsigned(mlp_norm_gain), 16'd256);
        chk("busy_nostart", mlp_start_mlp, 1'b0);
        step();
        chk("busy_hold", cfg_busy, 1'b1);
        mlp_state_in = 4'd0;
        step();
        chk("apply_cycle_gain", $unsigned(mlp_norm_gain), 16'd256);
        step();
        chk("apply_gain", $unsigned(mlp_norm_gain), 16'h0200);
        chk("apply_busy_clr", cfg_busy, 1'b0);
        chk("apply_start_not_yet", mlp_start_mlp, 1'b0);
        step();
        chk("start_release", mlp_start_mlp, 1'b1);
        step();
        chk("start_one_cycle", mlp_start_mlp, 1'b0);

        // Commit + start together while idle
        cfg_wr(4'd1, 8'h03);
        cfg_commit = 1; ctrl_start_mlp = 1;
        step();
        cfg_commit = 0; ctrl_start_mlp = 0;
        chk("idle_cs_gain", $unsigned(mlp_norm_gain), 16'h0300);
        chk("idle_cs_start", mlp_start_mlp, 1'b1);
        chk("idle_cs_busy", cfg_busy, 1'b0);
        step();
        chk("idle_cs_start_end", mlp_start_mlp, 1'b0);

        // Result capture, overrun, ack
        mlp_state_in = 4'd8;
        step();
        mlp_state_in = 4'd9;
        mlp_acc_in = {32'd7, 32'd1000, 32'hFFFF_FFFB};
        step();
        chk("cap_not_yet", result_valid, 1'b0);
        step();
        chk("cap_valid", result_valid, 1'b1);
        chk("cap_acc", result_acc, {32'd7, 32'd1000, 32'hFFFF_FFFB});
        chk("cap_ovf0", result_ovf, 1'b0);
        mlp_acc_in = {32'd1, 32'd2, 32'd3};
        step();
        chk("dwell_no_recap", result_acc, {32'd7, 32'd1000, 32'hFFFF_FFFB});
        mlp_state_in = 4'd8;
        step();
        mlp_state_in = 4'd9;
        mlp_acc_in = {32'd9, 32'hFFFF_FFFF, 32'd42};
        step();
        step();
        chk("ovf_set", result_ovf, 1'b1);
        chk("ovf_acc", result_acc, {32'd9, 32'hFFFF_FFFF, 32'd42});
        result_ack = 1;
        step();
        result_ack = 0;
        chk("ack_valid", result_valid, 1'b0);
        chk("ack_ovf", result_ovf, 1'b0);
        mlp_state_in = 4'd8;
        step();
        mlp_state_in = 4'd9;
        mlp_acc_in = {32'd5, 32'd6, 32'd7};
        step();
        step();
        chk("cap3_valid", result_valid, 1'b1);
        mlp_state_in = 4'd8;
        step();
        mlp_state_in = 4'd9;
        mlp_acc_in = {32'd8, 32'd9, 32'd10};
        step();
        result_ack = 1;
        step();
        result_ack = 0;
        chk("cap_ack_valid", result_valid, 1'b1);
        chk("cap_ack_ovf", result_ovf, 1'b0);
        chk("cap_ack_acc", result_acc, {32'd8, 32'd9, 32'd10});

        // Reset while commit pending and result valid
        mlp_state_in = 4'd3;
        step();
        cfg_wr(4'd0, 8'h55);
        cfg_commit = 1; ctrl_start_mlp = 1;
        step();
        cfg_commit = 0; ctrl_start_mlp = 0;
        chk("prerst_busy", cfg_busy, 1'b1);
        rst_n = 1'b0;
        #2;
        chk("arst_busy", cfg_busy, 1'b0);
        chk("arst_valid", result_valid, 1'b0);
        chk("arst_ovf", result_ovf, 1'b0);
        chk("arst_acc", result_acc, '0);
        chk_identity("arst");
        mlp_state_in = 4'd0;
        #2;
        rst_n = 1'b1;
        step();
        step();
        step();
        chk("postrst_gain", $unsigned(mlp_norm_gain), 16'd256);
        chk("postrst_start", mlp_start_mlp, 1'b0);
        chk("postrst_busy", cfg_busy, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
